// File: rtl/crm_rst_seq.sv
// Purpose : reset/clock-enable sequencer for the clock-reset manager (PLL lock -> clocks on -> ordered reset release -> soft resets).
// Latency : every output is registered and changes one i_clk edge after the condition that causes it.
// Backpress: none; soft-reset requests are queued in a pending vector and serviced lowest domain first.
//
// Ports:
//   i_clk, i_rstn     always-on reference clock, async active-low reset
//   i_pll_lock        synchronised PLL lock
//   i_sw_rst_req      per-domain soft reset request pulses
//   o_clk_en, o_rstn  per-domain clock-gate enables and reset releases
//   o_sw_ack          one-cycle pulse when a soft reset completes
//   o_seq_done        high in RUN and during soft resets
//   o_busy            high while sequencing or servicing a soft reset
// Optional macro CRM_RST_SEQ_STATUS_EN adds o_state and o_lock_loss_cnt.
module crm_rst_seq #(
    parameter int NUM_DOM  = 4,
    parameter int LOCK_CNT = 1024,
    parameter int STEP_CNT = 16,
    parameter int HOLD_CNT = 8,
    parameter int CNT_W    = 16
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_pll_lock,
    input  logic [NUM_DOM-1:0] i_sw_rst_req,
    output logic [NUM_DOM-1:0] o_clk_en,
    output logic [NUM_DOM-1:0] o_rstn,
    output logic [NUM_DOM-1:0] o_sw_ack,
    output logic               o_seq_done,
    output logic               o_busy
`ifdef CRM_RST_SEQ_STATUS_EN
    ,
    output logic [2:0]         o_state,
    output logic [7:0]         o_lock_loss_cnt
`endif
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] STEP_TC = CNT_W'(STEP_CNT - 1);
    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CNT - 1);
    localparam logic [IDX_W-1:0] LAST_DOM = IDX_W'(NUM_DOM - 1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_LOCK_STB  = 3'd1,
        S_CLK_ON    = 3'd2,
        S_RST_REL   = 3'd3,
        S_RUN       = 3'd4,
        S_SW_ASSERT = 3'd5,
        S_SW_GATE   = 3'd6,
        S_SW_UNGATE = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt, low_idx;
    logic               low_vld;
    logic [NUM_DOM-1:0] pend_q, pend_d, pend_set, pend_clr;
    logic [NUM_DOM-1:0] clk_en_q, clk_en_d, rstn_q, rstn_d, ack_q, ack_d;
    logic               done_q, done_d, busy_q, busy_d;
    logic               lock_lost;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        clk_en_d  = clk_en_q;
        rstn_d    = rstn_q;
        ack_d     = '0;
        pend_clr  = '0;
        lock_lost = 1'b0;
        // Counter saturates rather than wrapping.
        cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_d     = cnt_inc;
        idx_nxt   = idx_q + IDX_W'(1);
        // Requests only count once the sequencer has reached RUN.
        pend_set  = done_q ? i_sw_rst_req : '0;

        // Lowest pending domain wins: scan downward so the last hit is the lowest.
        low_vld = 1'b0;
        low_idx = '0;
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_vld = 1'b1;
                low_idx = IDX_W'(i);
            end
        end

        case (state_q)
            S_WAIT_LOCK: begin
                clk_en_d = '0;
                rstn_d   = '0;
                cnt_d    = '0;
                if (i_pll_lock) state_d = S_LOCK_STB;
            end
            S_LOCK_STB: begin
                if (!i_pll_lock) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_TC) begin
                    state_d  = S_CLK_ON;
                    clk_en_d = '1;
                    cnt_d    = '0;
                end
            end
            S_CLK_ON: begin
                if (cnt_q == STEP_TC) begin
                    state_d   = S_RST_REL;
                    rstn_d[0] = 1'b1;
                    idx_d     = '0;
                    cnt_d     = '0;
                end
            end
            S_RST_REL: begin
                if (cnt_q == STEP_TC) begin
                    cnt_d = '0;
                    if (idx_q == LAST_DOM) begin
                        state_d = S_RUN;
                    end else begin
                        rstn_d[idx_nxt] = 1'b1;
                        idx_d           = idx_nxt;
                    end
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (low_vld) begin
                    state_d           = S_SW_ASSERT;
                    pend_clr[low_idx] = 1'b1;
                    idx_d             = low_idx;
                    rstn_d[low_idx]   = 1'b0;
                end
            end
            S_SW_ASSERT: begin
                if (cnt_q == HOLD_TC) begin
                    state_d         = S_SW_GATE;
                    clk_en_d[idx_q] = 1'b0;
                    cnt_d           = '0;
                end
            end
            S_SW_GATE: begin
                if (cnt_q == HOLD_TC) begin
                    state_d         = S_SW_UNGATE;
                    clk_en_d[idx_q] = 1'b1;
                    cnt_d           = '0;
                end
            end
            default: begin // S_SW_UNGATE
                if (cnt_q == HOLD_TC) begin
                    state_d       = S_RUN;
                    rstn_d[idx_q] = 1'b1;
                    ack_d[idx_q]  = 1'b1;
                    cnt_d         = '0;
                end
            end
        endcase

        // Set wins over clear so a re-request of the domain in service is kept.
        pend_d = (pend_q & ~pend_clr) | pend_set;

        // Lock loss once clocks may be running tears everything down, aborting any soft reset.
        if (!i_pll_lock && (state_q != S_WAIT_LOCK) && (state_q != S_LOCK_STB)) begin
            lock_lost = 1'b1;
            state_d   = S_WAIT_LOCK;
            cnt_d     = '0;
            idx_d     = '0;
            pend_d    = '0;
            clk_en_d  = '0;
            rstn_d    = '0;
            ack_d     = '0;
        end

        done_d = (state_d == S_RUN) || (state_d == S_SW_ASSERT) ||
                 (state_d == S_SW_GATE) || (state_d == S_SW_UNGATE);
        busy_d = (state_d != S_WAIT_LOCK) && (state_d != S_RUN);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= S_WAIT_LOCK;
            cnt_q    <= '0;
            idx_q    <= '0;
            pend_q   <= '0;
            clk_en_q <= '0;
            rstn_q   <= '0;
            ack_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            clk_en_q <= clk_en_d;
            rstn_q   <= rstn_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign o_clk_en   = clk_en_q;
    assign o_rstn     = rstn_q;
    assign o_sw_ack   = ack_q;
    assign o_seq_done = done_q;
    assign o_busy     = busy_q;

`ifdef CRM_RST_SEQ_STATUS_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            loss_cnt_q <= '0;
        end else if (lock_lost && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign o_state         = state_q;
    assign o_lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: doc/crm_rst_seq.md
Name: crm_rst_seq

Overview:
- Reset/clock-enable sequencer for the DNPU clock-reset manager.
- Waits for stable PLL lock, then enables the domain clocks (100/200/300/600 MHz groups) with their resets held.
- Releases the domain resets one at a time in fixed order.
- In RUN, services per-domain software reset requests with an assert, gate, ungate, release sequence.
- Sits beside crm on the always-on reference clock; drives crm's clock-gate enables and reset-release inputs.

Parameters:
- NUM_DOM, 4, number of clock/reset domains (domain 0 released first).
- LOCK_CNT, 1024, consecutive cycles i_pll_lock must stay high before clocks are enabled.
- STEP_CNT, 16, cycles between successive sequencing steps.
- HOLD_CNT, 8, cycles per phase of a software domain reset.
- CNT_W, 16, width of the internal step counter; must hold max(LOCK_CNT, STEP_CNT, HOLD_CNT).

Ports:
- i_clk  input  1  always-on reference clock (xin domain).
- i_rstn  input  1  asynchronous active-low reset (from POR).
- i_pll_lock  input  1  PLL lock, already synchronised to i_clk.
- i_sw_rst_req  input  NUM_DOM  one-cycle pulse per domain requesting a soft reset.
- o_clk_en  output  NUM_DOM  per-domain clock-gate enable.
- o_rstn  output  NUM_DOM  per-domain active-low reset release.
- o_sw_ack  output  NUM_DOM  one-cycle pulse when a domain's soft reset completes.
- o_seq_done  output  1  high while in RUN or a SW_* state.
- o_busy  output  1  high in LOCK_STB, CLK_ON, RST_REL and SW_* states.

Behaviour:
- Reset: one clock, i_clk; i_rstn is asynchronous, active-low.
  - While i_rstn=0: all outputs 0, state WAIT_LOCK, counter 0, domain index 0, pending vector 0.
  - All outputs are registered.
- WAIT_LOCK: o_clk_en=0, o_rstn=0. When i_pll_lock=1, go to LOCK_STB with cnt=0.
- LOCK_STB: cnt increments each cycle while lock=1.
  - Lock=0: return to WAIT_LOCK.
  - cnt==LOCK_CNT-1: go to CLK_ON. o_clk_en is set to all ones on that edge.
- CLK_ON: clocks run with resets held.
  - After STEP_CNT cycles, o_rstn[0] is set and the state moves to RST_REL with idx=0.
- RST_REL: every STEP_CNT cycles, o_rstn[idx+1] is set and idx increments.
  - STEP_CNT cycles after o_rstn[NUM_DOM-1] rises: go to RUN and set o_seq_done=1.
  - Net timing: o_clk_en rises LOCK_CNT+1 cycles after lock rises. o_rstn[k] rises (k+1)*STEP_CNT cycles after o_clk_en. o_seq_done rises NUM_DOM*STEP_CNT+STEP_CNT cycles after o_clk_en.
- Pending vector:
  - i_sw_rst_req bits are OR-ed into pending only while o_seq_done=1; otherwise they are dropped.
  - Set has priority over clear in the same cycle, so a re-request of the domain in service is serviced again.
- RUN: if pending is non-zero, select the lowest set bit d, clear it, and go to SW_ASSERT. On that edge o_rstn[d]=0.
- SW_ASSERT: hold HOLD_CNT cycles with the clock running, then o_clk_en[d]=0 and go to SW_GATE.
- SW_GATE: hold HOLD_CNT cycles, then o_clk_en[d]=1 and go to SW_UNGATE.
- SW_UNGATE: hold HOLD_CNT cycles, then o_rstn[d]=1, o_sw_ack[d]=1 for one cycle, and return to RUN.
  - Other domains are unaffected throughout a soft reset.
  - Back-to-back pending requests leave at least one RUN cycle between services.
- Lock loss: i_pll_lock=0 in any state after LOCK_STB causes, on the next edge:
  - o_clk_en=0, o_rstn=0, o_seq_done=0, o_sw_ack=0;
  - pending cleared, cnt=0, state WAIT_LOCK.
  - A soft reset in progress is aborted with no ack.
- Counter: saturates at its terminal value and never wraps. cnt resets to 0 on every state change.

Optional Feature:
- Macro: CRM_RST_SEQ_STATUS_EN.
- Defined: adds two ports.
  - o_state (output, 3 bits): encoding WAIT_LOCK=0, LOCK_STB=1, CLK_ON=2, RST_REL=3, RUN=4, SW_ASSERT=5, SW_GATE=6, SW_UNGATE=7.
  - o_lock_loss_cnt (output, 8 bits): saturating count of lock-loss events after LOCK_STB; reset to 0, cleared only by i_rstn.
- Undefined: neither port exists and the counter logic is absent. All other behaviour is identical.

Test Plan:
Settings for all scenarios: NUM_DOM=4, LOCK_CNT=8, STEP_CNT=4, HOLD_CNT=2.
- Power-up: i_rstn deasserted, i_pll_lock steady high from T0.
  - o_clk_en=4'hF at T0+9.
  - o_rstn = 4'h1, 4'h3, 4'h7, 4'hF at T0+13, +17, +21, +25.
  - o_seq_done=1 at T0+29; o_busy=0 after that.
- Lock glitch: lock high for 5 cycles, low for 1, then high.
  - Stays in WAIT_LOCK/LOCK_STB with o_clk_en=0.
  - Full count restarts from the re-rise: o_clk_en rises 9 cycles after it.
- Soft reset: in RUN, pulse i_sw_rst_req=4'b0100 at T.
  - o_rstn[2]=0 at T+2; o_clk_en[2]=0 at T+4; o_clk_en[2]=1 at T+6.
  - o_rstn[2]=1 and o_sw_ack=4'b0100 at T+8.
  - Domains 0, 1 and 3 stay constant.
- Simultaneous requests 4'b1001: domain 0 is serviced fully first, then domain 3. Two ack pulses in that order.
- Lock loss during SW_GATE: all o_clk_en=0, o_rstn=0, o_seq_done=0 next cycle. No o_sw_ack. Re-lock replays the full sequence.
- Request during RST_REL: i_sw_rst_req=4'h2 before o_seq_done is dropped. No soft reset occurs after RUN.
